fifo_burst_reader: RTL

- Read-domain consumer that sits directly downstream of the dual-clock almost-full/almost-empty FIFO.
- Drains the FIFO in bursts of BURST_LEN words onto a valid/ready stream with an end-of-burst marker.
- Uses the FIFO's almost-empty flag to decide when a full burst is available, and a programmable timeout to flush partial bursts.
- Absorbs the FIFO RAM's one-cycle read latency with a 2-entry output buffer, so downstream backpressure never drops or duplicates a word.

---
 rtl/fifo_burst_reader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// Burst-mode consumer for the read side of an almost-full/almost-empty FIFO.
// Issues FIFO reads in bursts and presents them on a valid/ready stream with a last marker.
module fifo_burst_reader #(
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LEN     = 4,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     Read_clock___i,
    input  logic                     rst_async_la_i,
    input  logic                     enable_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
    input  logic                     fifo_empty_i,
    input  logic                     fifo_almost_empty_i,
    input  logic [DATA_WIDTH-1:0]    fifo_data_i,
    output logic                     fifo_rd_en_o,
    output logic [DATA_WIDTH-1:0]    m_data_o,
    output logic                     m_valid_o,
    output logic                     m_last_o,
    input  logic                     m_ready_i,
    output logic                     busy_o
);
    localparam int               CNT_W       = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;

    logic [1:0]               r_state;
    logic                     r_partial;
    logic [CNT_W-1:0]         r_rem;
    logic [CNT_W-1:0]         r_issued;
    logic [TIMEOUT_WIDTH-1:0] r_timer;
    logic                     r_inflight;
    logic                     r_inflight_final;
    logic [1:0]               r_occ;
    logic [DATA_WIDTH-1:0]    r_head_data;
    logic [DATA_WIDTH-1:0]    r_tail_data;
    logic                     r_head_last;
    logic                     r_tail_last;

    logic       w_pop;
    logic       w_cap_last;
    logic       w_timeout_hit;
    logic [2:0] w_pending;

    assign w_pop         = m_valid_o & m_ready_i;
    assign w_pending     = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_timeout_hit = (timeout_i != '0) && (r_timer == timeout_i - TIMEOUT_WIDTH'(1));

    // A read is only issued when the buffer is guaranteed a free slot for it next cycle.
    assign fifo_rd_en_o = (r_state == S_BURST) & ~fifo_empty_i & (r_issued < r_rem)
                        & (w_pending < 3'd2);

    // Partial bursts also end on the word that leaves the FIFO empty.
    assign w_cap_last = r_inflight_final | (r_partial & fifo_empty_i);

    assign m_valid_o = (r_occ != 2'd0);
    assign m_data_o  = r_head_data;
    assign m_last_o  = r_head_last;
    assign busy_o    = (r_state != S_IDLE) | m_valid_o;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Read_clock___i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            r_state   <= S_IDLE;
            r_partial <= 1'b0;
            r_rem     <= '0;
            r_issued  <= '0;
            r_timer   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i && !fifo_empty_i) begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    if (!fifo_almost_empty_i) begin
                        r_state   <= S_BURST;
                        r_partial <= 1'b0;
                        r_rem     <= BURST_LEN_C;
                        r_issued  <= '0;
                    end else if (w_timeout_hit) begin
                        r_state   <= S_BURST;
                        r_partial <= 1'b1;
                        r_rem     <= BURST_LEN_C;
                        r_issued  <= '0;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + TIMEOUT_WIDTH'(1);
                    end
                end
                S_BURST: begin
                    if (fifo_rd_en_o) begin
                        r_issued <= r_issued + CNT_W'(1);
                    end
                    if (r_inflight && w_cap_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the two buffer entries are plain registers, so they are reset too; stream data reads 0 out of reset.
    always_ff @(posedge Read_clock___i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            r_inflight       <= 1'b0;
            r_inflight_final <= 1'b0;
            r_occ            <= 2'd0;
            r_head_data      <= '0;
            r_tail_data      <= '0;
            r_head_last      <= 1'b0;
            r_tail_last      <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en_o;
            if (fifo_rd_en_o) begin
                r_inflight_final <= (r_issued + CNT_W'(1) == r_rem);
            end
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_data <= fifo_data_i;
                        r_head_last <= w_cap_last;
                    end else begin
                        r_tail_data <= fifo_data_i;
                        r_tail_last <= w_cap_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head_data <= r_tail_data;
                    r_head_last <= r_tail_last;
                    r_occ       <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head_data <= fifo_data_i;
                        r_head_last <= w_cap_last;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= fifo_data_i;
                        r_tail_last <= w_cap_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
